cordic_vector_phase: RTL and testbench
======================================

CORDIC_VECTOR_PHASE -- requirements
Module: cordic_vector_phase

Interface
REQ-001 The module SHALL have parameter ITER, default 16, giving the number of CORDIC micro-rotation stages (fixed at 16 for this release).
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port resest, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port i_in, input, 14 bits, signed: in-phase sample.
REQ-005 The module SHALL have port q_in, input, 14 bits, signed: quadrature sample.
REQ-006 The module SHALL have port in_valid, input, 1 bit: i_in/q_in are sampled when high.
REQ-007 The module SHALL have port phase_o, output, 16 bits, unsigned: atan2(q,i) in degrees, 9.7 format, range 0..46079 (0 to <360 deg).
REQ-008 The module SHALL have port mag_o, output, 16 bits, unsigned: vector magnitude times CORDIC gain K=1.64676, uncompensated.
REQ-009 The module SHALL have port out_valid, output, 1 bit: high for one cycle per result.

Function
REQ-010 The datapath SHALL be fully pipelined: stage 0 (fold), stages 1..16 (micro-rotations), stage 17 (output); one new sample accepted every cycle.
REQ-011 For a sample taken at edge E0, the result SHALL appear on phase_o/mag_o with out_valid=1 after edge E17 (latency 17 cycles), independent of in_valid history.
REQ-012 A valid bit SHALL travel alongside each stage; stages advance every cycle; phase_o/mag_o SHALL update only when the stage-17 valid bit is 1 and hold otherwise.
REQ-013 Internal x,y SHALL be 18-bit signed, loaded as the sign-extended input shifted left 2; internal z SHALL be 26-bit signed, degrees times 2^16.
REQ-014 Stage 0 fold: if i_in<0, x0=-i, y0=-q, z0=180*2^16; else x0=i, y0=q, z0=0; i_in=-8192 SHALL fold to +8192 without overflow.
REQ-015 Stage k (k=0..15), vectoring mode: if y>=0 then x+=y>>>k, y-=x>>>k, z+=ROTk; else x-=y>>>k, y+=x>>>k, z-=ROTk; all shifts arithmetic and using the previous stage's values.
REQ-016 ROT0..ROT15 SHALL be 2949120, 1740992, 919872, 466944, 234368, 117312, 58688, 29312, 14656, 7360, 3648, 1856, 896, 448, 256, 128; these are the rotation-mode NCO table, so the two blocks share one angle scale.
REQ-017 Stage 17 SHALL add 360*2^16 to z when z<0, then set phase_o=(z+256)>>9; a rounded value of 46080 SHALL wrap to 0.
REQ-018 Stage 17 SHALL set mag_o=x16>>2, truncated; x16 is non-negative by construction, and the maximum (about 19081) SHALL fit without saturation.
REQ-019 Input (0,0) SHALL yield phase_o=0 and mag_o=0.
REQ-020 Inputs on the axes SHALL give exact quadrant angles within tolerance: +i gives 0, +q gives 11520, -i gives 23040, -q gives 34560.
REQ-021 Angle error SHALL be at most ±3 LSB of phase_o; magnitude error SHALL be at most ±4 LSB of the ideal K*sqrt(i^2+q^2).

Reset
REQ-022 While resest=1, all pipeline registers, valid bits, phase_o, mag_o and out_valid SHALL be 0, asynchronously.
REQ-023 Samples in flight when reset asserts SHALL be discarded; after resest deasserts, out_valid SHALL stay 0 until 17 cycles after the first accepted sample.
REQ-024 in_valid sampled on the first rising edge after deassertion SHALL be accepted normally.

Verification
REQ-025 Drive (i,q)=(8191,0), one valid cycle -> 17 cycles later out_valid=1 for exactly one cycle, phase_o=0±3 (or 46077..46079), mag_o=13489±4.
REQ-026 Drive (0,8191), (-8192,0), (0,-8191) on consecutive cycles -> three consecutive out_valid pulses with phase_o 11520, 23040, 34560 (each ±3).
REQ-027 Drive (5000,5000), then (-5000,-5000) -> phase_o 5760±3 and mag_o 11644±4, then phase_o 28800±3 and mag_o 11644±4.
REQ-028 Drive a 1 kHz-equivalent NCO ramp of 360 angles at amplitude 8000 with in_valid continuously high -> every output within tolerance; phase_o monotonic apart from a single 46079->0 wrap.
REQ-029 Drive a valid pattern 1,0,1,1,0 -> out_valid shows the same pattern delayed by 17 cycles, with phase_o/mag_o held through the gaps.
REQ-030 Assert resest with 5 samples in flight -> outputs go to 0 immediately; no stale out_valid appears after release; the next sample returns a correct result 17 cycles after it is accepted.

Source files
------------

// File: rtl/cordic_vector_phase.sv
// Pipelined vectoring-mode CORDIC: converts an (i,q) sample into its phase
// in degrees (9.7 format, 0..<360) and its gain-scaled magnitude.
module cordic_vector_phase #(
  parameter int ITER = 16
) (
  input  logic        clock,
  input  logic        resest,
  input  logic [13:0] i_in,
  input  logic [13:0] q_in,
  input  logic        in_valid,
  output logic [15:0] phase_o,
  output logic [15:0] mag_o,
  output logic        out_valid
);

  localparam logic signed [25:0] Z_180      = 26'sd11796480;
  localparam logic signed [25:0] Z_360      = 26'sd23592960;
  localparam logic [15:0]        PHASE_FULL = 16'd46080;

  // Same angle table as the rotation-mode NCO so both blocks agree on scale.
  localparam logic signed [25:0] ROT_TAB [0:15] = '{
    26'sd2949120, 26'sd1740992, 26'sd919872, 26'sd466944,
    26'sd234368,  26'sd117312,  26'sd58688,  26'sd29312,
    26'sd14656,   26'sd7360,    26'sd3648,   26'sd1856,
    26'sd896,     26'sd448,     26'sd256,    26'sd128
  };

  logic signed [17:0] x_q [0:ITER];
  logic signed [17:0] x_d [0:ITER];
  logic signed [17:0] y_q [0:ITER];
  logic signed [17:0] y_d [0:ITER];
  logic signed [25:0] z_q [0:ITER];
  logic signed [25:0] z_d [0:ITER];
  logic               v_q [0:ITER];
  logic               v_d [0:ITER];
  logic               zero_q [0:ITER];
  logic               zero_d [0:ITER];

  logic [15:0] phase_q, phase_d;
  logic [15:0] mag_q, mag_d;
  logic        out_valid_q, out_valid_d;

  logic signed [17:0] i_ext, q_ext;
  logic signed [25:0] z_wrap;
  logic [26:0]        z_round;
  logic [15:0]        phase_new;
  logic [15:0]        mag_new;

  always_comb begin
    i_ext = {{2{i_in[13]}}, i_in, 2'b00};
    q_ext = {{2{q_in[13]}}, q_in, 2'b00};

    // Fold the left half-plane onto the right so the micro-rotations only
    // ever have to cover -90..+90 degrees; -8192 negates cleanly in 18 bits.
    if (i_in[13]) begin
      x_d[0] = -i_ext;
      y_d[0] = -q_ext;
      z_d[0] = Z_180;
    end else begin
      x_d[0] = i_ext;
      y_d[0] = q_ext;
      z_d[0] = '0;
    end
    v_d[0]    = in_valid;
    zero_d[0] = (i_in == 14'd0) && (q_in == 14'd0);

    for (int k = 0; k < ITER; k++) begin
      v_d[k+1]    = v_q[k];
      zero_d[k+1] = zero_q[k];
      if (!y_q[k][17]) begin
        x_d[k+1] = x_q[k] + (y_q[k] >>> k);
        y_d[k+1] = y_q[k] - (x_q[k] >>> k);
        z_d[k+1] = z_q[k] + ROT_TAB[k];
      end else begin
        x_d[k+1] = x_q[k] - (y_q[k] >>> k);
        y_d[k+1] = y_q[k] + (x_q[k] >>> k);
        z_d[k+1] = z_q[k] - ROT_TAB[k];
      end
    end

    z_wrap    = z_q[ITER][25] ? (z_q[ITER] + Z_360) : z_q[ITER];
    z_round   = {1'b0, z_wrap} + 27'd256;
    phase_new = 16'(z_round >> 9);
    mag_new   = 16'(x_q[ITER] >>> 2);

    phase_d     = phase_q;
    mag_d       = mag_q;
    out_valid_d = v_q[ITER];
    // A zero vector never steers y negative, so its z is meaningless.
    if (v_q[ITER]) begin
      phase_d = (zero_q[ITER] || (phase_new == PHASE_FULL)) ? 16'd0 : phase_new;
      mag_d   = mag_new;
    end
  end

  always_ff @(posedge clock or posedge resest) begin
    if (resest) begin
      for (int k = 0; k <= ITER; k++) begin
        x_q[k]    <= '0;
        y_q[k]    <= '0;
        z_q[k]    <= '0;
        v_q[k]    <= 1'b0;
        zero_q[k] <= 1'b0;
      end
      phase_q     <= '0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k <= ITER; k++) begin
        x_q[k]    <= x_d[k];
        y_q[k]    <= y_d[k];
        z_q[k]    <= z_d[k];
        v_q[k]    <= v_d[k];
        zero_q[k] <= zero_d[k];
      end
      phase_q     <= phase_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign phase_o   = phase_q;
  assign mag_o     = mag_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cordic_vector_phase.sv
// Directed bench for cordic_vector_phase: axis/diagonal vectors, latency,
// valid gaps with hold, reset flush and a full-circle ramp.
module tb_cordic_vector_phase;

  logic        clock = 1'b0;
  logic        resest;
  logic [13:0] i_in;
  logic [13:0] q_in;
  logic        in_valid;
  logic [15:0] phase_o;
  logic [15:0] mag_o;
  logic        out_valid;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [15:0] got_ph_q[$];
  logic [15:0] got_mag_q[$];
  int          got_cyc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_mag_q[$];

  int pat_v [5] = '{1, 0, 1, 1, 0};
  int pat_p [5] = '{11520, 11520, 23040, 34560, 34560};

  localparam real PI = 3.14159265358979;

  cordic_vector_phase #(.ITER(16)) dut (
    .clock     (clock),
    .resest    (resest),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .phase_o   (phase_o),
    .mag_o     (mag_o),
    .out_valid (out_valid)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      got_ph_q.push_back(phase_o);
      got_mag_q.push_back(mag_o);
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int circ_dist(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = -d;
    if (d > 23040) d = 46080 - d;
    return d;
  endfunction

  // checks
  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int got, input int exp, input int tol, input bit circ);
    int d;
    tests++;
    d = circ ? circ_dist(got, exp) : ((got > exp) ? got - exp : exp - got);
    assert (d <= tol) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d +/-%0d", tag, got, exp, tol);
    end
  endtask

  task automatic check_next(input string tag, input int exp_ph, input int exp_mag,
                            input int exp_cyc, input int ph_tol, input int mag_tol);
    logic [15:0] ph;
    logic [15:0] mg;
    int          cy;
    tests++;
    assert (got_ph_q.size() != 0) else begin
      fails++;
      $error("FAIL %s_present: got 0 results expected 1", tag);
    end
    if (got_ph_q.size() != 0) begin
      ph = got_ph_q.pop_front();
      mg = got_mag_q.pop_front();
      cy = got_cyc_q.pop_front();
      chk_tol({tag, "_phase"}, int'(ph), exp_ph, ph_tol, 1'b1);
      chk_tol({tag, "_mag"}, int'(mg), exp_mag, mag_tol, 1'b0);
      chk_eq({tag, "_cycle"}, cy, exp_cyc);
    end
  endtask

  // driver
  task automatic drive(input int i, input int q, input bit v, output int acc);
    @(negedge clock);
    i_in     = 14'(i);
    q_in     = 14'(q);
    in_valid = v;
    acc      = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (got_ph_q.size() >= n) break;
      @(negedge clock);
      #1;
    end
  endtask

  initial begin
    int a, b, dec, prev, ii, qq, ep, em;
    real ang, ea;
    logic [15:0] ph, mg;
    int cy;

    resest   = 1'b1;
    in_valid = 1'b0;
    i_in     = '0;
    q_in     = '0;
    repeat (3) @(negedge clock);
    #1;
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_phase", phase_o, 0);
    chk_eq("rst_mag", mag_o, 0);

    // sample presented on the first edge after release
    @(negedge clock);
    resest   = 1'b0;
    i_in     = 14'd8191;
    q_in     = 14'd0;
    in_valid = 1'b1;
    a        = cyc + 1;
    idle(1);
    wait_results(1, 40);
    repeat (4) @(negedge clock);
    #1;
    chk_eq("t025_count", got_ph_q.size(), 1);
    check_next("t025", 0, 13489, a + 17, 3, 4);

    // remaining axes back to back
    drive(0, 8191, 1'b1, a);
    drive(-8192, 0, 1'b1, b);
    drive(0, -8191, 1'b1, b);
    idle(1);
    wait_results(3, 40);
    repeat (3) @(negedge clock);
    #1;
    chk_eq("t026_count", got_ph_q.size(), 3);
    check_next("t026_q", 11520, 13489, a + 17, 3, 4);
    check_next("t026_ni", 23040, 13490, a + 18, 3, 4);
    check_next("t026_nq", 34560, 13489, a + 19, 3, 4);

    // zero vector
    drive(0, 0, 1'b1, a);
    idle(1);
    wait_results(1, 40);
    check_next("t019", 0, 0, a + 17, 0, 0);

    // diagonals
    drive(5000, 5000, 1'b1, a);
    drive(-5000, -5000, 1'b1, b);
    idle(1);
    wait_results(2, 40);
    check_next("t027_pp", 5760, 11644, a + 17, 3, 4);
    check_next("t027_nn", 28800, 11644, a + 18, 3, 4);

    // valid pattern 1,0,1,1,0 with garbage on the idle slots
    drive(0, 8191, 1'b1, a);
    drive(1234, -777, 1'b0, b);
    drive(-8192, 0, 1'b1, b);
    drive(0, -8191, 1'b1, b);
    drive(-3000, 2500, 1'b0, b);
    for (int c = 0; c < 40; c++) begin
      if (cyc == a + 17) break;
      @(negedge clock);
      #1;
    end
    chk_eq("t029_align", cyc, a + 17);
    for (int j = 0; j < 5; j++) begin
      chk_eq($sformatf("t029_valid%0d", j), out_valid, pat_v[j]);
      chk_tol($sformatf("t029_phase%0d", j), int'(phase_o), pat_p[j], 3, 1'b1);
      chk_tol($sformatf("t029_mag%0d", j), int'(mag_o), 13489, 4, 1'b0);
      @(negedge clock);
      #1;
    end
    got_ph_q.delete();
    got_mag_q.delete();
    got_cyc_q.delete();

    // reset with five samples in flight
    drive(1000, 2000, 1'b1, b);
    drive(3000, -100, 1'b1, b);
    drive(-4000, 500, 1'b1, b);
    drive(7000, 7000, 1'b1, b);
    drive(-1, -1, 1'b1, b);
    @(negedge clock);
    resest   = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_eq("t030_rst_valid", out_valid, 0);
    chk_eq("t030_rst_phase", phase_o, 0);
    chk_eq("t030_rst_mag", mag_o, 0);
    repeat (2) @(negedge clock);
    resest = 1'b0;
    repeat (25) @(negedge clock);
    #1;
    chk_eq("t030_no_stale", got_ph_q.size(), 0);
    drive(5000, -5000, 1'b1, a);
    idle(1);
    wait_results(1, 40);
    check_next("t030_after", 40320, 11644, a + 17, 3, 4);

    // full-circle ramp starting at 180 degrees, one wrap expected
    for (int k = 0; k < 360; k++) begin
      ang = real'(180 + k) * PI / 180.0;
      ii  = int'(8000.0 * $cos(ang));
      qq  = int'(8000.0 * $sin(ang));
      ea  = $atan2(real'(qq), real'(ii)) * 180.0 / PI;
      if (ea < 0.0) ea = ea + 360.0;
      ep  = int'(ea * 128.0);
      if (ep >= 46080) ep = ep - 46080;
      em  = int'(1.64676 * $sqrt(real'(ii * ii + qq * qq)));
      exp_q.push_back(16'(ep));
      exp_mag_q.push_back(16'(em));
      drive(ii, qq, 1'b1, b);
      if (k == 0) a = b;
    end
    idle(1);
    wait_results(360, 100);
    chk_eq("t028_count", got_ph_q.size(), 360);
    dec  = 0;
    prev = -1;
    for (int k = 0; k < 360; k++) begin
      if (got_ph_q.size() == 0) break;
      ph = got_ph_q.pop_front();
      mg = got_mag_q.pop_front();
      cy = got_cyc_q.pop_front();
      ep = int'(exp_q.pop_front());
      em = int'(exp_mag_q.pop_front());
      chk_tol($sformatf("t028_phase%0d", k), int'(ph), ep, 3, 1'b1);
      chk_tol($sformatf("t028_mag%0d", k), int'(mg), em, 4, 1'b0);
      chk_eq($sformatf("t028_cycle%0d", k), cy, a + 17 + k);
      if (prev >= 0 && int'(ph) < prev) dec++;
      prev = int'(ph);
    end
    chk_eq("t028_wraps", dec, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
